neuron_grid_core: RTL
=====================

# neuron_grid_core

Parametrised successor of the fixed 256-axon / 256-neuron grid. It merges controller and datapath into one sequential block with these generalisations:
- Configurable axon count, neuron count, potential width and weight width.
- Internal membrane-potential storage.
- Per-neuron leak, two reset modes and a negative floor.
- Saturating arithmetic.
- A valid/ready spike output that tolerates downstream backpressure.

It sits between the axon spike scheduler (spike vector, tick) and the spike router (spike handshake).

## Interface
Parameters:
- NUM_AXONS, 256: axons per core; ≥2.
- NUM_NEURONS, 256: neurons per core; ≥2.
- POT_W, 9: signed potential width.
- WEIGHT_W, 9: signed weight/leak width; ≤ POT_W.
- NUM_TYPES, 4: axon types; TYPE_W = clog2(NUM_TYPES).
- RESET_MODE, 0: 0 = load reset_potential on fire; 1 = subtract threshold on fire.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- reset, in, 1: asynchronous, active-high reset.
- tick, in, 1: start one full grid evaluation; sampled only in IDLE.
- axon_spikes, in, NUM_AXONS: spike vector; latched on accepted tick.
- axon_types, in, NUM_AXONS*TYPE_W: type of axon a at bits [a*TYPE_W +: TYPE_W]; static during evaluation.
- neuron_param, in, PARAM_W: parameters of the neuron at neuron_num. Stable while neuron_num is unchanged. Layout from LSB:
  - conn[NUM_AXONS]
  - weights NUM_TYPES×WEIGHT_W
  - leak WEIGHT_W
  - threshold POT_W
  - neg_floor POT_W
  - reset_potential POT_W
- neuron_num, out, clog2(NUM_NEURONS): neuron under evaluation; reset 0.
- axon_num, out, clog2(NUM_AXONS): axon under integration; reset 0.
- spike_valid, out, 1: spike pending; reset 0.
- spike_neuron, out, clog2(NUM_NEURONS): firing neuron index; reset 0.
- spike_ready, in, 1: downstream accepts spike.
- update_potential, out, 1: one-cycle pulse on potential write-back; reset 0.
- potential_out, out, POT_W: value written at update_potential; reset 0.
- busy, out, 1: high in any state other than IDLE; reset 0.
- done, out, 1: one-cycle pulse at end of evaluation; reset 0.
- error, out, 1: sticky; cleared only by reset; reset 0.

## Operation
- Storage: NUM_NEURONS×POT_W potential array; reset clears every entry to 0.
- States: IDLE, INTEGRATE, LEAK, FIRE, EMIT, NEXT, DONE.
- IDLE, on tick:
  - Latch axon_spikes.
  - Set neuron_num=0, axon_num=0.
  - Load acc from potential[0].
  - Go to INTEGRATE.
- INTEGRATE: one axon per cycle.
  - If spike[axon_num] & conn[axon_num]: acc = sat(acc + sext(weight[type[axon_num]])).
  - axon_num increments. At the last axon, go to LEAK and reset axon_num to 0.
- LEAK: acc = sat(acc + sext(leak)).
- FIRE: fire if acc ≥ threshold (signed compare).
  - If fired: new = reset_potential (RESET_MODE 0) or sat(acc − threshold) (RESET_MODE 1).
  - Else: new = acc < neg_floor ? neg_floor : acc.
  - Write new to potential[neuron_num]. Pulse update_potential with potential_out = new.
  - Next state is EMIT if fired, else NEXT.
- EMIT: hold spike_valid=1 and spike_neuron=neuron_num until the cycle where spike_ready=1, then go to NEXT. spike_valid and spike_neuron must not change while waiting.
- NEXT:
  - If neuron_num is last, go to DONE.
  - Else increment neuron_num, load acc from the new entry and go to INTEGRATE.
- DONE: done=1 for one cycle, then IDLE.
- sat(): clamp to [−2^(POT_W−1), 2^(POT_W−1)−1]. Compute at POT_W+1 bits, then clamp.
- Tick outside IDLE (including DONE): ignored; error set.
- Reset mid-operation: FSM returns to IDLE immediately. Any pending spike is dropped, and all potentials and outputs return to reset values.

## Timing
- Tick accepted at edge 0: INTEGRATE for neuron n starts in cycle 1 + n·(NUM_AXONS+3), with no backpressure.
- Per neuron without a spike: NUM_AXONS integrate cycles + LEAK + FIRE + NEXT.
- Each spike adds 1 + (cycles spike_ready is low) cycles.
- done is high in cycle NUM_NEURONS·(NUM_AXONS+3) + 1 + (total spike cycles).
- update_potential occurs in the FIRE cycle. spike_valid first rises in the cycle after FIRE.
- Combinational path: neuron_param and axon_types → acc within one cycle; no latency allowed on the param read.
- The earliest next tick is accepted in the cycle after done.

## Test plan
Default setup: NUM_AXONS=4, NUM_NEURONS=2, POT_W=9, WEIGHT_W=9, NUM_TYPES=4, spike_ready=1.
- Basic fire: spikes=4'b0011, conn=1111, types all 0, weight0=+3, leak=0, threshold=5, reset_potential=0 → neuron 0 acc=6, fires.
  - Required: spike_neuron=0, potential_out=0, done at cycle 2·7+1+1=16.
- Accumulate across ticks: weight0=+2, threshold=5, one active axon → potentials 2, 4, then fire on tick 3 (6≥5).
  - RESET_MODE 1 leaves potential 1.
- Saturation and floor:
  - weight=+255, 4 active axons → acc clamps at 255.
  - weight=−256, leak=−1, neg_floor=−10 → potential −10.
- Backpressure: fire neuron 0 with spike_ready low for 5 cycles → spike_valid/spike_neuron stable; neuron 1 starts only after handshake; done delayed by 6 cycles.
- Error: tick asserted during INTEGRATE → error=1 and stays high; evaluation completes unaffected.
- Reset mid-EMIT: spike_valid drops immediately; all outputs read 0; a subsequent tick with zero weights gives potential_out=0.

Source files
------------

// File: rtl/neuron_grid_core.sv
// Time-multiplexed spiking-neuron grid: integrates one axon per cycle into a
// per-neuron membrane potential, applies leak/fire/floor and emits spikes over valid/ready.
module neuron_grid_core #(
    parameter int NUM_AXONS   = 256,
    parameter int NUM_NEURONS = 256,
    parameter int POT_W       = 9,
    parameter int WEIGHT_W    = 9,
    parameter int NUM_TYPES   = 4,
    parameter int RESET_MODE  = 0,
    localparam int TYPE_W     = $clog2(NUM_TYPES),
    localparam int AXON_W     = $clog2(NUM_AXONS),
    localparam int NEURON_W   = $clog2(NUM_NEURONS),
    localparam int PARAM_W    = NUM_AXONS + (NUM_TYPES + 1) * WEIGHT_W + 3 * POT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [NUM_AXONS-1:0]       axon_spikes,
    input  logic [NUM_AXONS*TYPE_W-1:0] axon_types,
    input  logic [PARAM_W-1:0]         neuron_param,
    output logic [NEURON_W-1:0]        neuron_num,
    output logic [AXON_W-1:0]          axon_num,
    output logic                       spike_valid,
    output logic [NEURON_W-1:0]        spike_neuron,
    input  logic                       spike_ready,
    output logic                       update_potential,
    output logic signed [POT_W-1:0]    potential_out,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int OFF_LEAK  = NUM_AXONS + NUM_TYPES * WEIGHT_W;
    localparam int OFF_THR   = OFF_LEAK + WEIGHT_W;
    localparam int OFF_FLOOR = OFF_THR + POT_W;
    localparam int OFF_RSTP  = OFF_FLOOR + POT_W;

    localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
    localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};
    localparam logic [AXON_W-1:0]       LAST_AXON   = AXON_W'(NUM_AXONS - 1);
    localparam logic [NEURON_W-1:0]     LAST_NEURON = NEURON_W'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        IDLE, INTEGRATE, LEAK, FIRE, EMIT, NEXT, DONE
    } state_t;

    state_t                    state;
    logic [NUM_AXONS-1:0]      spikes_lat;
    logic signed [POT_W-1:0]   acc;
    logic                      fired;
    logic signed [POT_W-1:0]   potential [NUM_NEURONS];

    logic [TYPE_W-1:0]         axon_type [NUM_AXONS];
    logic signed [WEIGHT_W-1:0] weight   [NUM_TYPES];
    logic signed [WEIGHT_W-1:0] leak;
    logic signed [POT_W-1:0]   threshold;
    logic signed [POT_W-1:0]   neg_floor;
    logic signed [POT_W-1:0]   reset_pot;

    logic [TYPE_W-1:0]         cur_type;
    logic                      syn_hit;
    logic signed [POT_W-1:0]   acc_int;
    logic signed [POT_W-1:0]   acc_leak;
    logic                      fire_now;
    logic signed [POT_W-1:0]   new_pot;
    logic [NEURON_W-1:0]       next_neuron;

    function automatic logic signed [POT_W-1:0] sext_w(input logic signed [WEIGHT_W-1:0] w);
        logic signed [POT_W-1:0] r;
        for (int i = 0; i < POT_W; i++) r[i] = w[(i < WEIGHT_W) ? i : WEIGHT_W - 1];
        return r;
    endfunction

    // One guard bit is enough: the sum/difference of two POT_W values fits in POT_W+1.
    function automatic logic signed [POT_W-1:0] sat_sum(input logic signed [POT_W-1:0] a,
                                                        input logic signed [POT_W-1:0] b,
                                                        input logic                    sub);
        logic signed [POT_W:0] s;
        if (sub) s = {a[POT_W-1], a} - {b[POT_W-1], b};
        else     s = {a[POT_W-1], a} + {b[POT_W-1], b};
        if (s[POT_W] != s[POT_W-1]) return s[POT_W] ? POT_MIN : POT_MAX;
        return s[POT_W-1:0];
    endfunction

    for (genvar a = 0; a < NUM_AXONS; a++) begin : g_type
        assign axon_type[a] = axon_types[a*TYPE_W +: TYPE_W];
    end
    for (genvar t = 0; t < NUM_TYPES; t++) begin : g_weight
        assign weight[t] = neuron_param[NUM_AXONS + t*WEIGHT_W +: WEIGHT_W];
    end

    assign leak      = neuron_param[OFF_LEAK  +: WEIGHT_W];
    assign threshold = neuron_param[OFF_THR   +: POT_W];
    assign neg_floor = neuron_param[OFF_FLOOR +: POT_W];
    assign reset_pot = neuron_param[OFF_RSTP  +: POT_W];
    assign next_neuron = neuron_num + 1'b1;

    // Fire decision is taken on the leaked value in the LEAK cycle so that the
    // write-back pulse is registered and visible in the FIRE cycle.
    always_comb begin
        cur_type = axon_type[axon_num];
        syn_hit  = spikes_lat[axon_num] & neuron_param[axon_num];
        acc_int  = syn_hit ? sat_sum(acc, sext_w(weight[cur_type]), 1'b0) : acc;
        acc_leak = sat_sum(acc, sext_w(leak), 1'b0);
        fire_now = (acc_leak >= threshold);
        new_pot  = acc_leak;
        if (fire_now) begin
            if (RESET_MODE == 0) new_pot = reset_pot;
            else                 new_pot = sat_sum(acc_leak, threshold, 1'b1);
        end else if (acc_leak < neg_floor) begin
            new_pot = neg_floor;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) potential[i] <= '0;
        end else if (state == LEAK) begin
            potential[neuron_num] <= new_pot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            spikes_lat       <= '0;
            acc              <= '0;
            fired            <= 1'b0;
            neuron_num       <= '0;
            axon_num         <= '0;
            spike_valid      <= 1'b0;
            spike_neuron     <= '0;
            update_potential <= 1'b0;
            potential_out    <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            update_potential <= 1'b0;
            done             <= 1'b0;
            if (tick && state != IDLE) error <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        spikes_lat <= axon_spikes;
                        neuron_num <= '0;
                        axon_num   <= '0;
                        acc        <= potential[0];
                        busy       <= 1'b1;
                        state      <= INTEGRATE;
                    end
                end
                INTEGRATE: begin
                    acc <= acc_int;
                    if (axon_num == LAST_AXON) begin
                        axon_num <= '0;
                        state    <= LEAK;
                    end else begin
                        axon_num <= axon_num + 1'b1;
                    end
                end
                LEAK: begin
                    acc              <= acc_leak;
                    fired            <= fire_now;
                    potential_out    <= new_pot;
                    update_potential <= 1'b1;
                    state            <= FIRE;
                end
                FIRE: begin
                    if (fired) begin
                        spike_valid  <= 1'b1;
                        spike_neuron <= neuron_num;
                        state        <= EMIT;
                    end else begin
                        state <= NEXT;
                    end
                end
                EMIT: begin
                    if (spike_ready) begin
                        spike_valid <= 1'b0;
                        state       <= NEXT;
                    end
                end
                NEXT: begin
                    if (neuron_num == LAST_NEURON) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        neuron_num <= next_neuron;
                        acc        <= potential[next_neuron];
                        state      <= INTEGRATE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
